// File: rtl/tri_pkg.sv
// Shared definitions for the triangle setup stage: record layout, arithmetic widths, FSM states.
package tri_pkg;

    localparam int REC_W   = 240;
    localparam int VTX_W   = 80;
    localparam int NUM_VTX = 3;

    localparam int X_LSB   = 0;
    localparam int X_W     = 16;
    localparam int Y_LSB   = 16;
    localparam int Y_W     = 16;
    localparam int Z_LSB   = 32;
    localparam int Z_W     = 16;
    localparam int COL_LSB = 48;
    localparam int COL_W   = 32;

    localparam int DIFF_W  = 17;
    localparam int PROD_W  = 34;
    localparam int AREA_W  = 35;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAPTURE,
        ST_MUL0,
        ST_MUL1,
        ST_DECIDE,
        ST_OUT
    } state_t;

endpackage

// File: rtl/tri_bbox_clamp.sv
// Combinational min/max of three signed coordinates, clamped to 0..LIMIT-1, plus off-screen flag.
module tri_bbox_clamp #(
    parameter int LIMIT = 320
) (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    output logic [15:0] lo,
    output logic [15:0] hi,
    output logic        off
);

    localparam logic signed [16:0] LIM_M1 = 17'(LIMIT - 1);

    logic signed [15:0] sa, sb, sc;
    logic signed [15:0] mn, mx;

    assign sa = a;
    assign sb = b;
    assign sc = c;

    always_comb begin
        mn = sa;
        if (sb < mn) mn = sb;
        if (sc < mn) mn = sc;
        mx = sa;
        if (sb > mx) mx = sb;
        if (sc > mx) mx = sc;
        lo  = mn[15] ? 16'd0 : mn;
        hi  = (17'(mx) > LIM_M1) ? LIM_M1[15:0] : mx;
        off = mx[15] || (17'(mn) > LIM_M1);
    end

endmodule

// File: rtl/triangle_setup.sv
// Triangle setup: pops a record, computes doubled area on one shared multiplier, clamps bbox, culls.
// Build option: define TRI_BACKFACE_CULL_EN to drop clockwise triangles instead of re-winding them.
module triangle_setup
    import tri_pkg::*;
#(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REC_W-1:0]   fifo_data,
    input  logic               fifo_empty,
    output logic               fifo_pull,
    output logic [REC_W-1:0]   tri_vtx,
    output logic [AREA_W-1:0]  tri_area,
    output logic [15:0]        tri_xmin,
    output logic [15:0]        tri_xmax,
    output logic [15:0]        tri_ymin,
    output logic [15:0]        tri_ymax,
    output logic               tri_valid,
    input  logic               tri_ready,
    output logic [15:0]        cull_count
);

`ifdef TRI_BACKFACE_CULL_EN
    localparam bit CULL_BACK = 1'b1;
`else
    localparam bit CULL_BACK = 1'b0;
`endif

    state_t                    state_reg;
    logic [REC_W-1:0]          vtx_reg;
    logic signed [PROD_W-1:0]  p0_reg, p1_reg;
    logic [15:0]               xmin_reg, xmax_reg, ymin_reg, ymax_reg;
    logic                      off_reg;

    logic [15:0]               vx [NUM_VTX];
    logic [15:0]               vy [NUM_VTX];

    for (genvar gi = 0; gi < NUM_VTX; gi++) begin : g_unpack
        assign vx[gi] = vtx_reg[VTX_W*gi + X_LSB +: X_W];
        assign vy[gi] = vtx_reg[VTX_W*gi + Y_LSB +: Y_W];
    end

    // Shared multiplier: operand pair selected by which product step we are in.
    logic signed [DIFF_W-1:0]  dx_op, dy_op;
    logic signed [PROD_W-1:0]  prod;

    always_comb begin
        if (state_reg == ST_MUL1) begin
            dx_op = DIFF_W'($signed(vx[2])) - DIFF_W'($signed(vx[0]));
            dy_op = DIFF_W'($signed(vy[1])) - DIFF_W'($signed(vy[0]));
        end else begin
            dx_op = DIFF_W'($signed(vx[1])) - DIFF_W'($signed(vx[0]));
            dy_op = DIFF_W'($signed(vy[2])) - DIFF_W'($signed(vy[0]));
        end
    end

    assign prod = dx_op * dy_op;

    logic [15:0] bx_lo, bx_hi, by_lo, by_hi;
    logic        bx_off, by_off;

    tri_bbox_clamp #(.LIMIT(SCREEN_W)) u_clamp_x (
        .a   (vx[0]),
        .b   (vx[1]),
        .c   (vx[2]),
        .lo  (bx_lo),
        .hi  (bx_hi),
        .off (bx_off)
    );

    tri_bbox_clamp #(.LIMIT(SCREEN_H)) u_clamp_y (
        .a   (vy[0]),
        .b   (vy[1]),
        .c   (vy[2]),
        .lo  (by_lo),
        .hi  (by_hi),
        .off (by_off)
    );

    logic signed [AREA_W-1:0] area, neg_area;
    logic                     is_back, drop;
    logic [REC_W-1:0]         vtx_swapped;

    assign area        = AREA_W'(p0_reg) - AREA_W'(p1_reg);
    assign neg_area    = -area;
    assign is_back     = area[AREA_W-1];
    assign drop        = (area == '0) || off_reg || (CULL_BACK && is_back);
    // Exchanging v1 and v2 reverses the winding so survivors are always counter-clockwise.
    assign vtx_swapped = {vtx_reg[VTX_W +: VTX_W], vtx_reg[2*VTX_W +: VTX_W], vtx_reg[0 +: VTX_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            fifo_pull  <= 1'b0;
            tri_valid  <= 1'b0;
            tri_vtx    <= '0;
            tri_area   <= '0;
            tri_xmin   <= '0;
            tri_xmax   <= '0;
            tri_ymin   <= '0;
            tri_ymax   <= '0;
            cull_count <= '0;
            vtx_reg    <= '0;
            p0_reg     <= '0;
            p1_reg     <= '0;
            xmin_reg   <= '0;
            xmax_reg   <= '0;
            ymin_reg   <= '0;
            ymax_reg   <= '0;
            off_reg    <= 1'b0;
        end else begin
            fifo_pull <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    fifo_pull <= 1'b1;
                    state_reg <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    vtx_reg   <= fifo_data;
                    state_reg <= ST_MUL0;
                end
                ST_MUL0: begin
                    p0_reg    <= prod;
                    xmin_reg  <= bx_lo;
                    xmax_reg  <= bx_hi;
                    ymin_reg  <= by_lo;
                    ymax_reg  <= by_hi;
                    off_reg   <= bx_off || by_off;
                    state_reg <= ST_MUL1;
                end
                ST_MUL1: begin
                    p1_reg    <= prod;
                    state_reg <= ST_DECIDE;
                end
                ST_DECIDE: begin
                    if (drop) begin
                        if (cull_count != 16'hFFFF) cull_count <= cull_count + 16'd1;
                        state_reg <= ST_IDLE;
                    end else begin
                        tri_valid <= 1'b1;
                        tri_vtx   <= is_back ? vtx_swapped : vtx_reg;
                        tri_area  <= is_back ? neg_area : area;
                        tri_xmin  <= xmin_reg;
                        tri_xmax  <= xmax_reg;
                        tri_ymin  <= ymin_reg;
                        tri_ymax  <= ymax_reg;
                        state_reg <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (tri_ready) begin
                        tri_valid <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_setup.sv
// Scoreboard bench for triangle_setup: directed timing cases plus randomized triangles vs a reference model.
`timescale 1ns/1ps
module tb_triangle_setup;

    localparam int SW = 320;
    localparam int SH = 240;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [239:0] fifo_data;
    logic         fifo_empty;
    logic         fifo_pull;
    logic [239:0] tri_vtx;
    logic [34:0]  tri_area;
    logic [15:0]  tri_xmin, tri_xmax, tri_ymin, tri_ymax;
    logic         tri_valid;
    logic         tri_ready = 1'b0;
    logic [15:0]  cull_count;

    triangle_setup #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_pull  (fifo_pull),
        .tri_vtx    (tri_vtx),
        .tri_area   (tri_area),
        .tri_xmin   (tri_xmin),
        .tri_xmax   (tri_xmax),
        .tri_ymin   (tri_ymin),
        .tri_ymax   (tri_ymax),
        .tri_valid  (tri_valid),
        .tri_ready  (tri_ready),
        .cull_count (cull_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [239:0] vtx;
        logic [34:0]  area;
        logic [63:0]  bbox;
    } exp_t;

    exp_t         exp_q[$];
    int           tests = 0;
    int           fails = 0;
    int           exp_cull = 0;
    int           cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: synchronous-read memory, head registered onto fifo_data.
    logic [239:0] mem [64];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_pull) begin
            rd_ptr    <= rd_ptr + 1;
            fifo_data <= mem[(rd_ptr + 1) % 64];
        end else begin
            fifo_data <= mem[rd_ptr % 64];
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: doubled signed area, clamped bbox and the drop rules, from plain integers.
    task automatic push_tri(input int x0, input int y0, input int x1, input int y1, input int x2, input int y2);
        int           xs[3];
        int           ys[3];
        logic [239:0] rec, outrec;
        longint       area;
        int           mnx, mxx, mny, mxy;
        bit           drop;
        exp_t         e;
        xs = '{x0, x1, x2};
        ys = '{y0, y1, y2};
        rec = '0;
        mnx = x0; mxx = x0; mny = y0; mxy = y0;
        for (int i = 0; i < 3; i++) begin
            rec[80*i +: 16]      = 16'(xs[i]);
            rec[80*i + 16 +: 16] = 16'(ys[i]);
            rec[80*i + 32 +: 16] = 16'($urandom);
            rec[80*i + 48 +: 32] = $urandom;
            if (xs[i] < mnx) mnx = xs[i];
            if (xs[i] > mxx) mxx = xs[i];
            if (ys[i] < mny) mny = ys[i];
            if (ys[i] > mxy) mxy = ys[i];
        end
        area = longint'(x1 - x0) * longint'(y2 - y0) - longint'(x2 - x0) * longint'(y1 - y0);
        drop = (area == 0) || (mxx < 0) || (mnx > SW - 1) || (mxy < 0) || (mny > SH - 1);
`ifdef TRI_BACKFACE_CULL_EN
        if (area < 0) drop = 1'b1;
`endif
        if (drop) begin
            if (exp_cull < 65535) exp_cull++;
        end else begin
            outrec = rec;
            if (area < 0) begin
                outrec[80 +: 80]  = rec[160 +: 80];
                outrec[160 +: 80] = rec[80 +: 80];
                area = -area;
            end
            e.vtx  = outrec;
            e.area = 35'(area);
            e.bbox = {16'(mnx < 0 ? 0 : mnx), 16'(mxx > SW - 1 ? SW - 1 : mxx),
                      16'(mny < 0 ? 0 : mny), 16'(mxy > SH - 1 ? SH - 1 : mxy)};
            exp_q.push_back(e);
        end
        mem[wr_ptr % 64] = rec;
        wr_ptr++;
    endtask

    // Monitor: pops the scoreboard on each handshake and checks hold behaviour while stalled.
    logic         stall_prev = 1'b0;
    logic [239:0] held_vtx;
    logic [98:0]  held_rest;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (fifo_pull) check("pull_while_empty", 256'(fifo_empty), 256'(0));
            if (stall_prev) begin
                check("stall_vtx", 256'(tri_vtx), 256'(held_vtx));
                check("stall_rest", 256'({tri_valid, fifo_pull, tri_area, tri_xmin, tri_xmax, tri_ymin, tri_ymax}),
                      256'({1'b1, 1'b0, held_rest}));
            end
            if (tri_valid && tri_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 256'(1), 256'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out_vtx", 256'(tri_vtx), 256'(e.vtx));
                    check("out_area", 256'(tri_area), 256'(e.area));
                    check("out_bbox", 256'({tri_xmin, tri_xmax, tri_ymin, tri_ymax}), 256'(e.bbox));
                end
            end
            stall_prev = tri_valid && !tri_ready;
            held_vtx   = tri_vtx;
            held_rest  = {tri_area, tri_xmin, tri_xmax, tri_ymin, tri_ymax};
        end
    end

    task automatic drain(input bit rnd);
        int k = 0;
        while ((!fifo_empty || exp_q.size() != 0 || tri_valid) && k < 2000) begin
            tri_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            k++;
        end
        tri_ready = 1'b1;
        check("drain_timeout", 256'(k < 2000), 256'(1));
        repeat (8) tick();
        check("cull_count", 256'(cull_count), 256'(exp_cull));
    endtask

    initial begin
        int n, pcyc, vcyc, pulls, h, k;
        repeat (3) tick();
        check("rst_valid", 256'(tri_valid), 256'(0));
        check("rst_pull", 256'(fifo_pull), 256'(0));
        check("rst_cull", 256'(cull_count), 256'(0));
        check("rst_outs", 256'({tri_area, tri_xmin, tri_xmax, tri_ymin, tri_ymax}), 256'(0));
        check("rst_vtx", 256'(tri_vtx), 256'(0));
        rst_n = 1'b1;
        tick();

        // Latency of a single good triangle, rasterizer not yet ready.
        push_tri(0, 0, 10, 0, 0, 10);
        n = cyc; pcyc = -1; vcyc = -1; pulls = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fifo_pull) begin
                pulls++;
                if (pcyc < 0) pcyc = cyc;
            end
            if (tri_valid && vcyc < 0) vcyc = cyc;
        end
        check("pull_latency", 256'(pcyc - n), 256'(2));
        check("pull_count", 256'(pulls), 256'(1));
        check("valid_latency", 256'(vcyc - n), 256'(6));
        tick();
        drain(1'b0);

        push_tri(0, 0, 5, 5, 10, 10);
        push_tri(1, 2, 30, 4, 6, 50);
        push_tri(0, 0, 0, 10, 10, 0);
        drain(1'b0);

        push_tri(-50, -50, -40, -50, -50, -40);
        push_tri(-5, -5, 400, 0, 0, 300);
        drain(1'b0);

        // Two queued records behind a stalled rasterizer.
        tri_ready = 1'b0;
        push_tri(20, 20, 60, 25, 30, 90);
        push_tri(100, 100, 150, 100, 100, 180);
        k = 0;
        while (!tri_valid && k < 30) begin
            tick();
            k++;
        end
        check("stall_valid_timeout", 256'(k < 30), 256'(1));
        repeat (10) tick();
        tri_ready = 1'b1;
        @(negedge clk);
        h = cyc;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tri_valid && k < 20);
        check("second_out_gap", 256'(cyc - h), 256'(7));
        tick();
        drain(1'b0);

        // Reset while the triangle is in its second multiply step.
        tick();
        push_tri(0, 0, 10, 0, 0, 10);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 256'(tri_valid), 256'(0));
        check("midrst_pull", 256'(fifo_pull), 256'(0));
        check("midrst_cull", 256'(cull_count), 256'(0));
        void'(exp_q.pop_back());
        exp_cull = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        push_tri(3, 3, 40, 8, 12, 60);
        push_tri(7, 7, 7, 7, 20, 30);
        drain(1'b0);

        // Randomized triangles with a randomly stalling rasterizer.
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0)
                push_tri(int'($urandom_range(0, 8)), int'($urandom_range(0, 8)),
                         int'($urandom_range(0, 8)), int'($urandom_range(0, 8)),
                         int'($urandom_range(0, 8)), int'($urandom_range(0, 8)));
            else
                push_tri(int'($urandom_range(0, 460)) - 70, int'($urandom_range(0, 360)) - 60,
                         int'($urandom_range(0, 460)) - 70, int'($urandom_range(0, 360)) - 60,
                         int'($urandom_range(0, 460)) - 70, int'($urandom_range(0, 360)) - 60);
        end
        drain(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/triangle_setup.md
# triangle_setup

Triangle setup stage directly downstream of the triangle FIFO. It pops one 240-bit triangle record at a time and unpacks it into three vertices. It computes the signed doubled area with a single shared multiplier, plus a screen-clamped bounding box. It drops degenerate and off-screen triangles and hands survivors to the rasterizer over a valid/ready handshake.

## Interface
- SCREEN_W, 320, screen width in pixels; x clamp range 0..SCREEN_W-1
- SCREEN_H, 240, screen height in pixels; y clamp range 0..SCREEN_H-1
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- fifo_data  in  240  FIFO head record; synchronous-RAM output, valid one cycle after the head address settles
- fifo_empty  in  1  FIFO empty flag
- fifo_pull  out  1  one-cycle pop strobe
- tri_vtx  out  240  vertex record, same packing as input, possibly reordered
- tri_area  out  35  signed doubled area, always > 0 when valid
- tri_xmin, tri_xmax  out  16  clamped bounding box x
- tri_ymin, tri_ymax  out  16  clamped bounding box y
- tri_valid  out  1  output record valid
- tri_ready  in  1  rasterizer accepts
- cull_count  out  16  dropped-triangle counter, saturating at 0xFFFF

## Operation
- Record packing: vertex i occupies bits [80i+79:80i].
  - x: [15:0], signed
  - y: [31:16], signed
  - z: [47:32], unsigned
  - colour: [79:48]
- States and transitions:
  - IDLE: go to WAIT when !fifo_empty.
  - WAIT: always go to CAPTURE. This guarantees RAM read latency is honoured.
  - CAPTURE: latch fifo_data, assert fifo_pull for exactly this cycle; go to MUL0.
  - MUL0: product (x1-x0)*(y2-y0); register the bounding box; go to MUL1.
  - MUL1: product (x2-x0)*(y1-y0); go to DECIDE.
  - DECIDE: area = P0 - P1. Apply culling; either go to OUT or drop to IDLE.
  - OUT: tri_valid=1; on tri_ready go to IDLE.
- Arithmetic widths: coordinate differences 17-bit signed; products 34-bit signed; area 35-bit signed. No overflow is possible.
- Bounding box:
  - xmin = max(0, min(x0,x1,x2)); xmax = min(SCREEN_W-1, max(x0,x1,x2)). y likewise.
  - Compare as signed values.
- Drop conditions:
  - area == 0;
  - max x < 0, min x > SCREEN_W-1, max y < 0, or min y > SCREEN_H-1;
  - area < 0, only when backface culling is enabled.
- Each drop increments cull_count (saturating) and returns to IDLE.
- The block never asserts fifo_pull while fifo_empty=1, and never pulls twice without passing through IDLE and WAIT.
- Reset values: state IDLE; fifo_pull 0; tri_valid 0; all tri_* outputs 0; cull_count 0.
- Reset mid-operation: any captured triangle is discarded. The FIFO is reset by its own sync reset in the same system reset.

## Timing
- fifo_empty falls in cycle N: WAIT at N+1, CAPTURE/fifo_pull at N+2, MUL0 N+3, MUL1 N+4, DECIDE N+5.
- tri_valid rises at N+6.
- Minimum throughput with tri_ready held high: one triangle per 7 cycles.
- A dropped triangle occupies 6 cycles.
- While tri_valid && !tri_ready, all tri_* outputs are held stable and no pull occurs.
- tri_valid stays high until the handshake completes; it is deasserted in the cycle after the handshake.
- All outputs are registered. No combinational path exists from tri_ready or fifo_empty to any output.

## Configuration
- TRI_BACKFACE_CULL_EN defined: area < 0 is dropped and counted.
- TRI_BACKFACE_CULL_EN undefined: area < 0 is kept.
  - Vertices 1 and 2 are swapped in tri_vtx.
  - tri_area = -area.
  - Output is therefore always counter-clockwise.

## Structure
- Package tri_pkg holds:
  - vertex field offsets and widths;
  - the record width (240);
  - the state enumeration;
  - the area width (35).
- Sub-module tri_bbox_clamp: purely combinational min/max of three signed values, clamp, and off-screen flag. It is instantiated once each for x and y with SCREEN_W/SCREEN_H.

## Test plan
- Triangle (0,0),(10,0),(0,10) -> fifo_pull a single pulse at N+2, tri_valid at N+6, tri_area=100, bbox x 0..10 and y 0..10.
- Collinear (0,0),(5,5),(10,10) -> no tri_valid, cull_count=1, next record captured via IDLE/WAIT.
- Clockwise (0,0),(0,10),(10,0):
  - macro defined -> dropped, cull_count+1;
  - macro undefined -> tri_vtx has v1/v2 swapped, tri_area=100.
- Off-screen (-50,-50),(-40,-50),(-50,-40) -> dropped. Partially visible (-5,-5),(400,0),(0,300) -> bbox x 0..319, y 0..239.
- Two queued records with tri_ready low for 10 cycles -> outputs stable, fifo_pull stays 0. After tri_ready rises -> second record reaches OUT 7 cycles after the first handshake.
- rst_n low during MUL1 -> immediately tri_valid=0, fifo_pull=0, cull_count=0. After release, processing resumes from IDLE.
